// File: rtl/pcie_ats_csr_pkg.sv
// ---------------------------------------------------------------------------
// pcie_ats_csr_pkg
// Shared constants and types for the PCIe ATS capability CSR feature:
// register byte offsets, CAP_STATUS field positions, PF limit, the 64-bit
// CSR word type and the packed capability-vector struct.
// ---------------------------------------------------------------------------
package pcie_ats_csr_pkg;

  localparam int MAX_PFS = 16;

  localparam int OFF_DFH        = 'h00;
  localparam int OFF_SCRATCHPAD = 'h08;
  localparam int OFF_CAP_STATUS = 'h10;
  localparam int OFF_TOPOLOGY   = 'h18;
  localparam int OFF_ATS_EN_CTL = 'h20;
  localparam int OFF_TESTPAD    = 'h28;
  localparam int OFF_INV_CNT    = 'h40;
  localparam int INV_CNT_STRIDE = 8;

  localparam int CAP_ATS_LSB    = 0;
  localparam int CAP_VF_ATS_LSB = 16;
  localparam int CAP_PRS_LSB    = 32;
  localparam int CAP_PASID_LSB  = 48;

  localparam int          CNT_W   = 32;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef logic [63:0] csr_word_t;

  typedef struct packed {
    logic [15:0] pasid;
    logic [15:0] prs;
    logic [15:0] vf_ats;
    logic [15:0] ats;
  } cap_vec_t;

endpackage

// File: rtl/pcie_ats_inv_counter.sv
// ---------------------------------------------------------------------------
// pcie_ats_inv_counter
// One saturating 32-bit ATS invalidation counter.
// Ports:
//   clk, rst  clock, async active-high reset
//   en        counting allowed (per-PF ATS enable)
//   inc       one-cycle invalidation request
//   clr       clear request; an enabled increment in the same cycle wins
//             over the clear, leaving the counter at 1
//   count     current count
// ---------------------------------------------------------------------------
module pcie_ats_inv_counter
  import pcie_ats_csr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic hit;
  assign hit = en & inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= hit ? CNT_W'(1) : '0;
    end else if (hit && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pcie_ats_cap_csr.sv
// ---------------------------------------------------------------------------
// pcie_ats_cap_csr
// CSR feature exposing per-PF ATS / VF-ATS / PRS / PASID capability info,
// scratch/test registers, per-PF ATS enables and (optionally) per-PF ATS
// invalidation counters.
// Build option: OFS_PCIE_ATS_INV_CNT_EN builds the INV_CNT registers and
// counters; without it inv_pulse is ignored and 0x40+ reads return 0.
// Ports:
//   clk, rst                 clock, async active-high reset
//   cmd_valid/ready/write    command handshake (write=1, read=0)
//   cmd_addr, cmd_wdata      byte offset (bits [2:0] ignored), write data
//   rsp_valid/ready, rsp_data read response, one read outstanding
//   inv_pulse                per-PF one-cycle invalidation request
//   ats_en                   per-PF ATS enable to PCIe SS
// ---------------------------------------------------------------------------
module pcie_ats_cap_csr
  import pcie_ats_csr_pkg::*;
#(
  parameter int                 NUM_PFS        = 1,
  parameter int                 NUM_LINKS      = 1,
  parameter int                 ADDR_W         = 12,
  parameter logic [63:0]        DFH_VALUE      = 64'h0,
  parameter logic [NUM_PFS-1:0] ATS_CAP_VEC    = '0,
  parameter logic [NUM_PFS-1:0] VF_ATS_CAP_VEC = '0,
  parameter logic [NUM_PFS-1:0] PRS_CAP_VEC    = '0,
  parameter logic [NUM_PFS-1:0] PASID_CAP_VEC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [63:0]        cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [63:0]        rsp_data,
  input  logic [NUM_PFS-1:0] inv_pulse,
  output logic [NUM_PFS-1:0] ats_en
);

  cap_vec_t          caps;
  csr_word_t         cap_status;
  csr_word_t         topology;
  csr_word_t         rd_word;
  csr_word_t         scratchpad;
  csr_word_t         testpad;
  logic [NUM_PFS-1:0] ats_en_ctl;
  logic [ADDR_W-1:0] addr_al;
  logic              rd_acc;
  logic              wr_acc;

  assign caps.ats    = 16'(ATS_CAP_VEC);
  assign caps.vf_ats = 16'(VF_ATS_CAP_VEC);
  assign caps.prs    = 16'(PRS_CAP_VEC);
  assign caps.pasid  = 16'(PASID_CAP_VEC);

  assign cap_status = (64'(caps.ats)    << CAP_ATS_LSB)
                    | (64'(caps.vf_ats) << CAP_VF_ATS_LSB)
                    | (64'(caps.prs)    << CAP_PRS_LSB)
                    | (64'(caps.pasid)  << CAP_PASID_LSB);

  assign topology = {48'h0, 8'(NUM_LINKS), 8'(NUM_PFS)};

  assign addr_al   = {cmd_addr[ADDR_W-1:3], 3'b000};
  assign cmd_ready = !rsp_valid | rsp_ready;
  assign rd_acc    = cmd_valid & cmd_ready & !cmd_write;
  assign wr_acc    = cmd_valid & cmd_ready & cmd_write;
  assign ats_en    = ats_en_ctl;

`ifdef OFS_PCIE_ATS_INV_CNT_EN
  logic [CNT_W-1:0]  inv_cnt [NUM_PFS];
  logic [NUM_PFS-1:0] inv_clr;

  always_comb begin
    inv_clr = '0;
    for (int p = 0; p < NUM_PFS; p++) begin
      if (wr_acc && (addr_al == ADDR_W'(OFF_INV_CNT + INV_CNT_STRIDE * p))) begin
        inv_clr[p] = 1'b1;
      end
    end
  end

  // Counters see the enable as it stood before any same-cycle ATS_EN_CTL write.
  for (genvar p = 0; p < NUM_PFS; p++) begin : g_inv_cnt
    pcie_ats_inv_counter u_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (ats_en_ctl[p]),
      .inc   (inv_pulse[p]),
      .clr   (inv_clr[p]),
      .count (inv_cnt[p])
    );
  end

  logic unused_bits;
  assign unused_bits = ^cmd_addr[2:0];
`else
  logic unused_bits;
  assign unused_bits = ^{cmd_addr[2:0], inv_pulse};
`endif

  always_comb begin
    rd_word = '0;
    case (addr_al)
      ADDR_W'(OFF_DFH):        rd_word = DFH_VALUE;
      ADDR_W'(OFF_SCRATCHPAD): rd_word = scratchpad;
      ADDR_W'(OFF_CAP_STATUS): rd_word = cap_status;
      ADDR_W'(OFF_TOPOLOGY):   rd_word = topology;
      ADDR_W'(OFF_ATS_EN_CTL): rd_word = 64'(ats_en_ctl);
      ADDR_W'(OFF_TESTPAD):    rd_word = testpad;
      default:                 rd_word = '0;
    endcase
`ifdef OFS_PCIE_ATS_INV_CNT_EN
    for (int p = 0; p < NUM_PFS; p++) begin
      if (addr_al == ADDR_W'(OFF_INV_CNT + INV_CNT_STRIDE * p)) begin
        rd_word = {32'h0, inv_cnt[p]};
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratchpad <= '0;
      testpad    <= '0;
      ats_en_ctl <= '0;
    end else if (wr_acc) begin
      case (addr_al)
        ADDR_W'(OFF_SCRATCHPAD): scratchpad <= cmd_wdata;
        ADDR_W'(OFF_ATS_EN_CTL): ats_en_ctl <= cmd_wdata[NUM_PFS-1:0] & ATS_CAP_VEC;
        ADDR_W'(OFF_TESTPAD):    testpad    <= cmd_wdata;
        default: ;
      endcase
    end
  end

  // Read data is captured from pre-edge state; it is held until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (rd_acc) begin
      rsp_valid <= 1'b1;
      rsp_data  <= rd_word;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcie_ats_cap_csr.sv
module tb_pcie_ats_cap_csr;

  localparam int          NPF      = 4;
  localparam int          NLINKS   = 1;
  localparam logic [63:0] DFH      = 64'h3000_0001_2000_1A5C;
  localparam logic [3:0]  ATS_CAP  = 4'b0101;
  localparam logic [3:0]  VF_CAP   = 4'b0000;
  localparam logic [3:0]  PRS_CAP  = 4'b0001;
  localparam logic [3:0]  PAS_CAP  = 4'b0000;
`ifdef OFS_PCIE_ATS_INV_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic [3:0]  inv_pulse;
  logic [3:0]  ats_en;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pcie_ats_cap_csr #(
    .NUM_PFS(NPF), .NUM_LINKS(NLINKS), .ADDR_W(12), .DFH_VALUE(DFH),
    .ATS_CAP_VEC(ATS_CAP), .VF_ATS_CAP_VEC(VF_CAP),
    .PRS_CAP_VEC(PRS_CAP), .PASID_CAP_VEC(PAS_CAP)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .inv_pulse(inv_pulse), .ats_en(ats_en)
  );

  // ---------------- reference model ----------------
  logic [63:0] m_scratch, m_testpad, m_rd;
  logic [3:0]  m_ats;
  logic        m_rv;
  logic [31:0] m_cnt [NPF];

  task automatic model_reset();
    m_scratch = '0; m_testpad = '0; m_rd = '0; m_ats = '0; m_rv = 1'b0;
    for (int p = 0; p < NPF; p++) m_cnt[p] = '0;
  endtask

  function automatic logic [63:0] m_read(input logic [11:0] a);
    int          w;
    logic [63:0] r;
    w = int'(a) & ~7;
    r = '0;
    if (w == 'h00) r = DFH;
    else if (w == 'h08) r = m_scratch;
    else if (w == 'h10) begin
      for (int p = 0; p < NPF; p++) begin
        r[p]      = ATS_CAP[p];
        r[16 + p] = VF_CAP[p];
        r[32 + p] = PRS_CAP[p];
        r[48 + p] = PAS_CAP[p];
      end
    end
    else if (w == 'h18) r = 64'(NPF) + 64'(NLINKS) * 256;
    else if (w == 'h20) r = 64'(m_ats);
    else if (w == 'h28) r = m_testpad;
    else if (CNT_EN && w >= 'h40 && w < 'h40 + 8 * NPF) r = 64'(m_cnt[(w - 'h40) / 8]);
    return r;
  endfunction

  // Drive one cycle of inputs, let the edge happen, advance the model, settle.
  task automatic cycle(input bit v, input bit w, input logic [11:0] a,
                       input logic [63:0] d, input logic [3:0] pls, input bit rr);
    bit          acc;
    int          wa;
    logic [63:0] rv;
    logic [3:0]  ats_old;
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    inv_pulse = pls; rsp_ready = rr;
    @(posedge clk);
    acc     = v && (!m_rv || rr);
    rv      = m_read(a);
    ats_old = m_ats;
    wa      = int'(a) & ~7;
    if (acc && !w) begin m_rv = 1'b1; m_rd = rv; end
    else if (rr) m_rv = 1'b0;
    if (CNT_EN) begin
      for (int p = 0; p < NPF; p++) begin
        bit hit, clr;
        hit = pls[p] && ats_old[p];
        clr = acc && w && (wa == 'h40 + 8 * p);
        if (clr) m_cnt[p] = hit ? 32'd1 : 32'd0;
        else if (hit && m_cnt[p] != 32'hFFFF_FFFF) m_cnt[p] = m_cnt[p] + 1;
      end
    end
    if (acc && w) begin
      if (wa == 'h08) m_scratch = d;
      else if (wa == 'h20) m_ats = d[3:0] & ATS_CAP;
      else if (wa == 'h28) m_testpad = d;
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 12'h000, 64'h0, 4'h0, 1'b1);
  endtask

  task automatic do_read(input logic [11:0] a, output logic [63:0] d, output logic v);
    cycle(1'b1, 1'b0, a, 64'h0, 4'h0, 1'b1);
    d = rsp_data; v = rsp_valid;
    idle();
  endtask

  task automatic do_write(input logic [11:0] a, input logic [63:0] d);
    cycle(1'b1, 1'b1, a, d, 4'h0, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    inv_pulse = '0; rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (rsp_data !== 64'h0) begin n_bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    n_cmp++; if (ats_en !== 4'h0) begin n_bad++; $display("FAIL reset_ats_en got=%h exp=0", ats_en); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    rst = 1'b0;
    idle();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_ro_regs();
    logic [63:0] d; logic v;
    do_read(12'h000, d, v);
    n_cmp++; if (d !== DFH || v !== 1'b1) begin n_bad++; $display("FAIL dfh got=%h v=%b exp=%h", d, v, DFH); end
    do_read(12'h010, d, v);
    n_cmp++; if (d !== 64'h0000_0001_0000_0005) begin n_bad++; $display("FAIL cap_status got=%h exp=0000000100000005", d); end
    do_read(12'h018, d, v);
    n_cmp++; if (d !== 64'h0104) begin n_bad++; $display("FAIL topology got=%h exp=104", d); end
    do_read(12'h01F, d, v);
    n_cmp++; if (d !== 64'h0104) begin n_bad++; $display("FAIL topology_lowbits got=%h exp=104", d); end
    do_read(12'h030, d, v);
    n_cmp++; if (d !== 64'h0) begin n_bad++; $display("FAIL unmapped_30 got=%h exp=0", d); end
    do_read(12'h060, d, v);
    n_cmp++; if (d !== 64'h0) begin n_bad++; $display("FAIL inv_cnt_pf4 got=%h exp=0", d); end
  endtask

  task automatic test_scratch();
    logic [63:0] d, t; logic v;
    do_write(12'h008, 64'hDEAD_BEEF_0123_4567);
    do_read(12'h008, d, v);
    n_cmp++; if (d !== 64'hDEAD_BEEF_0123_4567) begin n_bad++; $display("FAIL scratch got=%h exp=deadbeef01234567", d); end
    do_write(12'h010, 64'hFFFF_FFFF_FFFF_FFFF);
    do_read(12'h010, d, v);
    n_cmp++; if (d !== 64'h0000_0001_0000_0005) begin n_bad++; $display("FAIL cap_ro got=%h exp=0000000100000005", d); end
    t = {$urandom, $urandom};
    do_write(12'h02C, t);
    do_read(12'h028, d, v);
    n_cmp++; if (d !== t) begin n_bad++; $display("FAIL testpad got=%h exp=%h", d, t); end
  endtask

  task automatic test_ats_en();
    logic [63:0] d; logic v;
    do_write(12'h020, 64'hF);
    n_cmp++; if (ats_en !== 4'b0101) begin n_bad++; $display("FAIL ats_en got=%b exp=0101", ats_en); end
    do_read(12'h020, d, v);
    n_cmp++; if (d !== 64'h5) begin n_bad++; $display("FAIL ats_en_ctl got=%h exp=5", d); end
  endtask

  task automatic test_inv_cnt();
    logic [63:0] d, e; logic v;
    do_write(12'h040, 64'h0);
    do_write(12'h048, 64'h0);
    cycle(1'b0, 1'b0, 12'h0, 64'h0, 4'b0011, 1'b1);
    cycle(1'b0, 1'b0, 12'h0, 64'h0, 4'b0011, 1'b1);
    cycle(1'b0, 1'b0, 12'h0, 64'h0, 4'b0001, 1'b1);
    do_read(12'h040, d, v);
    e = CNT_EN ? 64'd3 : 64'd0;
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL inv_cnt0 got=%h exp=%h", d, e); end
    do_read(12'h048, d, v);
    n_cmp++; if (d !== 64'h0) begin n_bad++; $display("FAIL inv_cnt1_disabled got=%h exp=0", d); end
    // read coincident with pulse returns the pre-pulse count
    cycle(1'b1, 1'b0, 12'h040, 64'h0, 4'b0001, 1'b1);
    d = rsp_data; idle();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL inv_cnt_read_pre got=%h exp=%h", d, e); end
    do_write(12'h040, 64'h1234);   // clear-with-pulse below
    cycle(1'b0, 1'b0, 12'h0, 64'h0, 4'b0001, 1'b1);
    cycle(1'b1, 1'b1, 12'h040, 64'h0, 4'b0001, 1'b1);
    do_read(12'h040, d, v);
    e = CNT_EN ? 64'd1 : 64'd0;
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL inv_clr_pulse got=%h exp=%h", d, e); end
    cycle(1'b1, 1'b1, 12'h048, 64'h0, 4'b0010, 1'b1);
    do_read(12'h048, d, v);
    n_cmp++; if (d !== 64'h0) begin n_bad++; $display("FAIL inv_clr_pulse_dis got=%h exp=0", d); end
  endtask

  task automatic test_saturation();
`ifdef OFS_PCIE_ATS_INV_CNT_EN
    logic [63:0] d; logic v;
    force dut.g_inv_cnt[0].u_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.g_inv_cnt[0].u_cnt.count;
    m_cnt[0] = 32'hFFFF_FFFE;
    repeat (3) cycle(1'b0, 1'b0, 12'h0, 64'h0, 4'b0001, 1'b1);
    do_read(12'h040, d, v);
    n_cmp++; if (d !== 64'hFFFF_FFFF) begin n_bad++; $display("FAIL inv_sat got=%h exp=ffffffff", d); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [11:0] addrs [4];
    logic [63:0] e;
    addrs[0] = 12'h000; addrs[1] = 12'h008; addrs[2] = 12'h010; addrs[3] = 12'h020;
    for (int i = 0; i < 4; i++) begin
      e = m_read(addrs[i]);
      cycle(1'b1, 1'b0, addrs[i], 64'h0, 4'h0, 1'b1);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== e) begin
        n_bad++; $display("FAIL b2b_%0d got=%h v=%b exp=%h", i, rsp_data, rsp_valid, e);
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [63:0] d0, d; logic v;
    cycle(1'b1, 1'b0, 12'h008, 64'h0, 4'h0, 1'b1);
    d0 = m_read(12'h008);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 12'h008, {$urandom, $urandom}, 4'h0, 1'b0);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || cmd_ready !== 1'b0) begin
        n_bad++; $display("FAIL stall_%0d data=%h v=%b rdy=%b exp=%h v=1 rdy=0", i, rsp_data, rsp_valid, cmd_ready, d0);
      end
    end
    idle();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release got=%b exp=0", rsp_valid); end
    do_read(12'h008, d, v);
    n_cmp++; if (d !== d0) begin n_bad++; $display("FAIL stall_write_blocked got=%h exp=%h", d, d0); end
  endtask

  task automatic test_random();
    logic [11:0] pick [14];
    logic [11:0] a;
    pick[0] = 12'h000; pick[1] = 12'h008; pick[2] = 12'h010; pick[3] = 12'h018;
    pick[4] = 12'h020; pick[5] = 12'h028; pick[6] = 12'h030; pick[7] = 12'h040;
    pick[8] = 12'h048; pick[9] = 12'h050; pick[10] = 12'h058; pick[11] = 12'h060;
    pick[12] = 12'h020; pick[13] = 12'h800;
    for (int i = 0; i < 400; i++) begin
      a = pick[$urandom_range(13)] | 12'($urandom_range(7));
      cycle($urandom_range(9) < 7, $urandom_range(1) == 1, a,
            {$urandom, $urandom}, 4'($urandom), $urandom_range(3) != 0);
      n_cmp++;
      if (rsp_valid !== m_rv || rsp_data !== m_rd || ats_en !== m_ats ||
          cmd_ready !== (!m_rv || rsp_ready)) begin
        n_bad++;
        $display("FAIL rand_%0d v=%b d=%h en=%b rdy=%b exp v=%b d=%h en=%b rdy=%b", i,
                 rsp_valid, rsp_data, ats_en, cmd_ready, m_rv, m_rd, m_ats, (!m_rv || rsp_ready));
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic v;
    do_write(12'h020, 64'h5);
    cycle(1'b1, 1'b0, 12'h020, 64'h0, 4'h0, 1'b1);
    cycle(1'b0, 1'b0, 12'h0, 64'h0, 4'h0, 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || ats_en !== 4'h0) begin
      n_bad++; $display("FAIL reset_mid v=%b en=%b exp v=0 en=0", rsp_valid, ats_en);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    do_read(12'h008, d, v);
    n_cmp++; if (d !== 64'h0) begin n_bad++; $display("FAIL reset_mid_scratch got=%h exp=0", d); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ro_regs();
    test_scratch();
    test_ats_en();
    test_inv_cnt();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pcie_ats_cap_csr.md
# pcie_ats_cap_csr

CSR feature block that exposes the PCIe subsystem's per-PF ATS/VF-ATS/PRS/PASID capability configuration to host software, holds scratchpad/testpad registers, drives per-PF ATS enables into the PCIe SS, and counts ATS invalidation requests per PF. It sits on the FIM CSR fabric behind a DFH header, between the host CSR path and the PCIe SS sideband, and is generalised over PF count, link count and capability vectors.

## Interface
- NUM_PFS, 1: number of PFs, legal 1..16.
- NUM_LINKS, 1: PCIe links, legal 1..255.
- ADDR_W, 12: byte-offset width within the feature.
- DFH_VALUE, 64'h0: value returned at offset 0x00.
- ATS_CAP_VEC / VF_ATS_CAP_VEC / PRS_CAP_VEC / PASID_CAP_VEC, all-zero: [NUM_PFS-1:0], bit p = capability present on PF p.
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte offset, 8-byte aligned (bits [2:0] ignored).
- cmd_wdata  in  64  write data.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  read data consumed.
- rsp_data  out  64  read data.
- inv_pulse  in  NUM_PFS  one-cycle ATS invalidation request per PF.
- ats_en  out  NUM_PFS  per-PF ATS enable to PCIe SS.

## Operation
- Map: 0x00 DFH (RO); 0x08 SCRATCHPAD (RW); 0x10 CAP_STATUS (RO: [15:0] ATS, [31:16] VF_ATS, [47:32] PRS, [63:48] PASID, bit p of each field = PF p, unused bits 0); 0x18 TOPOLOGY (RO: [7:0] NUM_PFS, [15:8] NUM_LINKS, rest 0); 0x20 ATS_EN_CTL (RW [NUM_PFS-1:0], written value ANDed with ATS_CAP_VEC; read returns stored value); 0x28 TESTPAD (RW); 0x40+8*p INV_CNT[p] for p<NUM_PFS ([31:0] count, [63:32] 0; any write clears).
- Reads of unmapped or p≥NUM_PFS offsets return 0; writes to RO/unmapped offsets ignored.
- ats_en = ATS_EN_CTL register.
- INV_CNT[p] increments on inv_pulse[p] only while ats_en[p]=1; saturates at 32'hFFFF_FFFF.
- Clear write and pulse same cycle: counter = 1 (if ats_en[p]), else 0.
- One read outstanding max; writes produce no response.

## Timing
- Reset values: cmd_ready 1 after reset, rsp_valid 0, rsp_data 0, ats_en 0, SCRATCHPAD/TESTPAD/ATS_EN_CTL/INV_CNT 0.
- cmd_ready = !rsp_valid | rsp_ready (combinational).
- Write accepted cycle N: register value visible from N+1; ats_en changes at N+1.
- Read accepted cycle N: rsp_valid high from N+1, rsp_data captured from register state at edge N (pre-update; pulse in cycle N not included, write in cycle N not included).
- rsp_data/rsp_valid held stable until rsp_ready; back-to-back reads at full rate when rsp_ready held 1.
- Reset mid-transaction: pending response dropped, rsp_valid 0 next cycle after assertion (async).

## Configuration
- OFS_PCIE_ATS_INV_CNT_EN defined: INV_CNT registers and per-PF counters built.
- Undefined: no counters, inv_pulse ignored, 0x40+ reads return 0, writes ignored.

## Structure
- Package pcie_ats_csr_pkg: register offset localparams, CAP_STATUS field LSB constants, max-PF constant (16), typedef for 64-bit CSR word and cap-vector struct.
- Sub-module pcie_ats_inv_counter: one saturating 32-bit counter with enable, increment, clear; generate-instantiated per PF under the macro.

## Test plan
- Reset, read 0x00/0x10/0x18 with NUM_PFS=4, ATS_CAP_VEC=4'b0101, PRS_CAP_VEC=4'b0001 -> DFH_VALUE, 64'h0000_0001_0000_0005, 64'h0104 (NUM_LINKS=1).
- Write 0x08=64'hDEAD_BEEF_0123_4567, read back -> same; write 0x10 -> CAP_STATUS unchanged.
- Write ATS_EN_CTL=4'hF with cap 4'b0101 -> ats_en=4'b0101 next cycle, read 0x20 -> 5.
- 3 pulses on PF0 with ats_en[0]=1 and 2 pulses on PF1 (ats_en[1]=0) -> INV_CNT0=3, INV_CNT1=0; clear write to 0x40 coincident with pulse -> 1.
- Force counter near 32'hFFFF_FFFE, 3 pulses -> reads 32'hFFFF_FFFF.
- Read with rsp_ready low 5 cycles -> rsp_data stable, cmd_ready 0; assert rst during pending read -> rsp_valid 0, ats_en 0.
